// File: rtl/m0_spi_pkg.sv
// Shared definitions for the SPI memory arbiter slice.
// Contents:
//   FRAME_LEN       number of phases in one serial frame
//   phase_t         phase counter type
//   *_START/CLK_END phase boundaries of the frame layout
//   CMD_READ/WRITE  command bytes sent MSB first at the start of a frame
//   state_t         arbiter states
//   cmd_byte()      selects the command byte for a transfer direction
package m0_spi_pkg;

  localparam int FRAME_LEN = 84;

  typedef logic [6:0] phase_t;

  localparam phase_t CMD_START  = 7'd2;
  localparam phase_t ADDR_START = 7'd18;
  localparam phase_t DATA_START = 7'd50;
  localparam phase_t CLK_END    = 7'd81;
  localparam phase_t PHASE_LAST = phase_t'(FRAME_LEN - 1);

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    ACK
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic rnw);
    return rnw ? CMD_READ : CMD_WRITE;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Word-level request bus between the two requesters and the SPI memory
// arbiter.
// Signals:
//   rN_req/rN_rnw/rN_addr/rN_wdata  request from requester N (0 = core,
//                                   1 = UART loader), held until rN_ack
//   rN_ack                          one-cycle completion pulse
//   rdata                           read data, valid in the ack cycle
//   busy                            a frame is in progress
//   gnt_id                          requester owning the current/last frame
// Modports: master = requester side, slave = arbiter side.
interface spi_mem_arbiter_if;

  logic        r0_req;
  logic        r0_rnw;
  logic [15:0] r0_addr;
  logic [15:0] r0_wdata;
  logic        r0_ack;

  logic        r1_req;
  logic        r1_rnw;
  logic [15:0] r1_addr;
  logic [15:0] r1_wdata;
  logic        r1_ack;

  logic [15:0] rdata;
  logic        busy;
  logic        gnt_id;

  modport master (
    output r0_req, r0_rnw, r0_addr, r0_wdata,
    output r1_req, r1_rnw, r1_addr, r1_wdata,
    input  r0_ack, r1_ack, rdata, busy, gnt_id
  );

  modport slave (
    input  r0_req, r0_rnw, r0_addr, r0_wdata,
    input  r1_req, r1_rnw, r1_addr, r1_wdata,
    output r0_ack, r1_ack, rdata, busy, gnt_id
  );

endinterface

// File: rtl/spi_frame_engine.sv
// On-demand generator for one 84-phase SPI memory frame.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a frame (phase 0 in the following cycle)
//   rnw, addr, wdata  transfer parameters, stable for the whole frame
//   miso              serial data from the memory
//   done              high during the last phase of the frame
//   rdata             read word, loaded at the end of read frames only
//   cs0, cs1          chip selects, active-low (addr[15] picks cs1)
//   sclk, mosi        SPI clock and serial data out
// All pin outputs are registered; they are computed from the phase the
// counter is about to enter so the pins line up with the phase register.
module spi_frame_engine
  import m0_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rnw,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        miso,
  output logic        done,
  output logic [15:0] rdata,
  output logic        cs0,
  output logic        cs1,
  output logic        sclk,
  output logic        mosi
);

  logic        active;
  phase_t      phase;
  logic [15:0] rx_shift;

  logic        nxt_active;
  phase_t      phase_nxt;
  logic [7:0]  cmd_b;
  logic        pin_cs0;
  logic        pin_cs1;
  logic        pin_clk;
  logic        pin_mosi;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    done       = active && (phase == PHASE_LAST);
    nxt_active = start || (active && !done);
    phase_nxt  = start ? '0 : phase + 7'd1;
    cmd_b      = cmd_byte(rnw);

    pin_cs0  = 1'b1;
    pin_cs1  = 1'b1;
    pin_clk  = 1'b0;
    pin_mosi = 1'b0;

    if (nxt_active && phase_nxt >= CMD_START) begin
      pin_cs0 = addr[15];
      pin_cs1 = ~addr[15];
      if (phase_nxt <= CLK_END)
        pin_clk = phase_nxt[0];
      // Each data bit spans an even/odd phase pair, so indices use phase>>1
      // and MOSI only moves on even phases.
      if (phase_nxt < ADDR_START)
        pin_mosi = cmd_b[3'((ADDR_START - 7'd1 - phase_nxt) >> 1)];
      else if (phase_nxt < DATA_START - 7'd2)
        pin_mosi = addr[4'((phase_nxt - ADDR_START) >> 1)];
      else if (phase_nxt >= DATA_START && phase_nxt <= CLK_END && !rnw)
        pin_mosi = wdata[4'((phase_nxt - DATA_START) >> 1)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      phase    <= '0;
      rx_shift <= '0;
      rdata    <= '0;
      cs0      <= 1'b1;
      cs1      <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      active <= nxt_active;
      if (nxt_active)
        phase <= phase_nxt;
      cs0  <= pin_cs0;
      cs1  <= pin_cs1;
      sclk <= pin_clk;
      mosi <= pin_mosi;
      // MISO is taken at the end of each odd (clock-high) data phase,
      // LSB first, so new bits enter at the top and move down.
      if (active && rnw && phase[0] && phase > DATA_START && phase <= CLK_END)
        rx_shift <= {miso, rx_shift[15:1]};
      // The visible word changes only when a read frame completes.
      if (done && rnw)
        rdata <= rx_shift;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbiter sharing one serial SPI memory bus (ROM on cs0, RAM on cs1)
// between requester 0 (core) and requester 1 (UART loader/debug).
// Parameters:
//   PRIO_FIXED  0 = round-robin on ties, 1 = requester 0 always wins ties
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   bus                  request bus (slave side)
//   spi_cs0, spi_cs1     chip selects, active-low
//   spi_clk, spi_mosi    SPI clock and serial out
//   spi_miso             serial in
// Flow: IDLE picks a winner and latches its command, FRAME runs one serial
// frame in the engine, ACK pulses the winner's ack for one cycle.
module spi_mem_arbiter
  import m0_spi_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  spi_mem_arbiter_if.slave bus,
  output logic             spi_cs0,
  output logic             spi_cs1,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  state_t      state;
  state_t      state_nxt;
  logic        last_gnt;
  logic        gnt_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        busy_q;
  logic        lat_rnw;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;

  logic        win;
  logic        grant;
  logic        frame_done;
  logic [15:0] eng_rdata;

  always_comb begin
    // A lone requester wins; on a tie the requester not served last wins,
    // unless requester 0 has fixed priority.
    win = bus.r1_req;
    if (bus.r0_req && bus.r1_req)
      win = PRIO_FIXED ? 1'b0 : ~last_gnt;

    grant     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          grant     = 1'b1;
          state_nxt = FRAME;
        end
      end
      FRAME:   if (frame_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      gnt_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      lat_rnw   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      ack0_q <= (state == FRAME) && frame_done && !gnt_q;
      ack1_q <= (state == FRAME) && frame_done && gnt_q;
      if (grant) begin
        last_gnt  <= win;
        gnt_q     <= win;
        lat_rnw   <= win ? bus.r1_rnw   : bus.r0_rnw;
        lat_addr  <= win ? bus.r1_addr  : bus.r0_addr;
        lat_wdata <= win ? bus.r1_wdata : bus.r0_wdata;
      end
    end
  end

  assign bus.r0_ack = ack0_q;
  assign bus.r1_ack = ack1_q;
  assign bus.busy   = busy_q;
  assign bus.gnt_id = gnt_q;
  assign bus.rdata  = eng_rdata;

  // The engine starts on the grant edge; its first two phases keep the pins
  // idle, so the latched command is in place before it is needed.
  spi_frame_engine u_engine (
    .clk   (clk),
    .rst   (rst),
    .start (grant),
    .rnw   (lat_rnw),
    .addr  (lat_addr),
    .wdata (lat_wdata),
    .miso  (spi_miso),
    .done  (frame_done),
    .rdata (eng_rdata),
    .cs0   (spi_cs0),
    .cs1   (spi_cs1),
    .sclk  (spi_clk),
    .mosi  (spi_mosi)
  );

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Shares the single serial SPI memory bus (ROM on CS0 for words 0000-7FFF, RAM on CS1 for words 8000-FFFF) between two word-level requesters: requester 0 is the M0 SUBLEQ core, requester 1 is the UART loader/debug port. It arbitrates pending requests and latches the winner's command. It then runs one 84-phase serial frame per transaction and returns read data with a one-cycle acknowledge. It sits between the requesters and the chip pins, replacing the free-running frame generator with an on-demand one.

## Interface
- PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rN_req  in  1  (N=0,1) transaction request, held until rN_ack
- rN_rnw  in  1  1 = read, 0 = write
- rN_addr  in  16  word address; bit 15 selects chip
- rN_wdata  in  16  write data
- rN_ack  out  1  one-cycle completion pulse
- rdata  out  16  read data, valid in the rN_ack cycle, held until the next frame completes
- busy  out  1  frame in progress
- gnt_id  out  1  requester owning the current/last frame
- spi_cs0, spi_cs1  out  1  chip selects, active-low
- spi_clk  out  1  SPI clock
- spi_mosi  out  1  serial out
- spi_miso  in  1  serial in

## Operation
- States: IDLE, FRAME, ACK.
- IDLE: if any rN_req, pick the winner, latch rnw/addr/wdata, set gnt_id, clear phase, go to FRAME.
- Pick rule with PRIO_FIXED=0: a lone requester wins; on a tie, the requester not granted last wins. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- FRAME: phase counter 0..83, frame layout:
  - phases 0-1: both CS high, clk 0, mosi 0.
  - from phase 2: the selected CS is low (addr[15]=0 selects cs0, 1 selects cs1); the other CS stays high.
  - spi_clk = phase[0] for phases 2-81, else 0.
  - MOSI changes only on even phases and holds across the odd phase.
  - phases 2-17: command byte 0000001R, MSB first, where R = rnw.
  - phases 18-47: addr[14:0], LSB first.
  - phases 48-49: 0.
  - phases 50-81, writes: wdata LSB first.
  - phases 50-81, reads: MOSI 0; sample miso on odd phases 51..81 into rdata, LSB first (shift right, MSB in).
  - phases 82-83: CS still low, clk 0.
- ACK: both CS high; pulse rN_ack for the granted requester; go to IDLE.
- rdata updates only on reads; writes leave it unchanged.
- Requests arriving during FRAME/ACK wait; they are evaluated in IDLE.
- A requester dropping req mid-frame is ignored; the frame completes and ack still pulses.
- A requester holding req after its ack is treated as a new request, subject to round-robin.
- Inputs change only while IDLE or after ack; the latched copies are used during the frame.

## Timing
- All outputs are registered.
- Reset values: cs0=cs1=1, spi_clk=0, mosi=0, rN_ack=0, busy=0, gnt_id=0, rdata=0000, state IDLE.
- Request seen in IDLE at cycle t: phase 0 at t+1, phase 83 at t+84, ACK at t+85, back in IDLE at t+86. Back-to-back frames occupy 86 cycles each.
- busy is high from t+1 through t+85.
- Reset mid-frame: next cycle both CS high, clk 0, mosi 0, no ack, pending frame discarded.

## Structure
- Package m0_spi_pkg: FRAME_LEN=84, phase boundary constants (CMD_START=2, ADDR_START=18, DATA_START=50, CLK_END=81), the state enum, and the read command byte.
- Sub-module spi_frame_engine: phase counter, pin generation and shift registers. Inputs: start, rnw, addr, wdata. Outputs: done, rdata.
- spi_mem_arbiter holds the request pick, latches and ack steering.

## Test plan
- Reset, then r0 read of 0x0005, miso driving 0xBEEF LSB-first on odd phases 51-81 -> cs0 low phases 2-83, command byte 0x03, address bits 1,0,1,0..., r0_ack at t+85, rdata=BEEF.
- r1 write addr 0x8003 data 0x1234 -> cs1 low, cs0 high, command byte 0x02, MOSI carries 0x1234 LSB-first phases 50-81, r1_ack at t+85, rdata unchanged.
- r0 and r1 request in the same cycle, held continuously, PRIO_FIXED=0 -> grants alternate 0,1,0,1; each ack is 86 cycles apart.
- Same as above with PRIO_FIXED=1 -> requester 0 granted every frame; r1 never acked while r0 is held.
- rst asserted at phase 40 -> next cycle cs0=cs1=1, clk=0, mosi=0, no ack; a fresh request afterwards completes normally.
- r0 drops req at phase 30 -> frame completes, r0_ack still pulses, state returns to IDLE.
